// File: rtl/anti_theft_pkg.sv
// Shared types and constants for the anti-theft controller datapath.
package anti_theft_pkg;

  localparam int TIME_W = 4;

  typedef enum logic [1:0] {
    SEL_ARM       = 2'd0,
    SEL_DRIVER    = 2'd1,
    SEL_PASSENGER = 2'd2,
    SEL_ALARM_ON  = 2'd3
  } interval_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } timer_state_t;

endpackage

// File: rtl/alarm_timer_sec_prescaler.sv
// Clock-cycle prescaler producing a combinational pulse at its terminal count.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic sec_pulse
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == TERMINAL) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
    end
  end

  assign sec_pulse = enable && (cnt == TERMINAL);

endmodule

// File: rtl/alarm_timer.sv
// Loads one of four programmed delays on start and counts it down in whole seconds.
module alarm_timer
  import anti_theft_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        interval_sel,
  input  logic              start_timer,
  input  logic              cancel,
  input  logic [TIME_W-1:0] T_ARM_DELAY,
  input  logic [TIME_W-1:0] T_DRIVER_DELAY,
  input  logic [TIME_W-1:0] T_PASSENGER_DELAY,
  input  logic [TIME_W-1:0] T_ALARM_ON,
  output logic              busy,
  output logic              tick,
  output logic              expired,
  output logic [TIME_W-1:0] remaining
);

  timer_state_t      state, state_n;
  logic [TIME_W-1:0] remaining_n;
  logic [TIME_W-1:0] sel_param;
  logic              tick_n, expired_n;
  logic              pre_clear, pre_enable, sec_pulse;

  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .clear     (pre_clear),
    .enable    (pre_enable),
    .sec_pulse (sec_pulse)
  );

  always_comb begin
    sel_param = T_ARM_DELAY;
    case (interval_sel_t'(interval_sel))
      SEL_ARM:       sel_param = T_ARM_DELAY;
      SEL_DRIVER:    sel_param = T_DRIVER_DELAY;
      SEL_PASSENGER: sel_param = T_PASSENGER_DELAY;
      SEL_ALARM_ON:  sel_param = T_ALARM_ON;
      default:       sel_param = T_ARM_DELAY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      busy      <= (state_n == COUNT);
      tick      <= tick_n;
      expired   <= expired_n;
    end
  end

  // Start has top priority so a restart swallows both cancel and a coinciding final tick.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    tick_n      = 1'b0;
    expired_n   = 1'b0;
    pre_clear   = 1'b0;
    pre_enable  = 1'b0;
    if (start_timer) begin
      state_n     = COUNT;
      remaining_n = sel_param;
      pre_clear   = 1'b1;
    end else if (state == COUNT) begin
      if (cancel) begin
        state_n     = IDLE;
        remaining_n = '0;
        pre_clear   = 1'b1;
      end else if (remaining == '0) begin
        state_n   = IDLE;
        expired_n = 1'b1;
      end else begin
        pre_enable = 1'b1;
        if (sec_pulse) begin
          tick_n      = 1'b1;
          remaining_n = remaining - TIME_W'(1);
          if (remaining == TIME_W'(1)) begin
            expired_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Directed and random checks of alarm_timer against an elapsed-time reference model.
module tb_alarm_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] interval_sel = 2'd0;
  logic       start_timer = 1'b0;
  logic       cancel = 1'b0;
  logic [3:0] t_arm = '0, t_driver = '0, t_passenger = '0, t_alarm = '0;
  logic       busy, tick, expired;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  // Reference model: a count is described by its start cycle and loaded length.
  int  cyc = 0;
  int  k = 0;
  int  m_n = 0;
  bit  active = 0;

  always #5 clk = ~clk;

  alarm_timer #(.TICKS_PER_SEC(T)) dut (
    .clk               (clk),
    .rst               (rst),
    .interval_sel      (interval_sel),
    .start_timer       (start_timer),
    .cancel            (cancel),
    .T_ARM_DELAY       (t_arm),
    .T_DRIVER_DELAY    (t_driver),
    .T_PASSENGER_DELAY (t_passenger),
    .T_ALARM_ON        (t_alarm),
    .busy              (busy),
    .tick              (tick),
    .expired           (expired),
    .remaining         (remaining)
  );

  function automatic int param_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return int'(t_arm);
      2'd1:    return int'(t_driver);
      2'd2:    return int'(t_passenger);
      default: return int'(t_alarm);
    endcase
  endfunction

  task automatic check_outputs(input logic eb, input logic et, input logic ee,
                               input logic [3:0] er, input string tag);
    checks++;
    assert (busy === eb) else begin
      errors++; $error("FAIL %s busy observed=%b expected=%b t=%0t", tag, busy, eb, $time);
    end
    checks++;
    assert (tick === et) else begin
      errors++; $error("FAIL %s tick observed=%b expected=%b t=%0t", tag, tick, et, $time);
    end
    checks++;
    assert (expired === ee) else begin
      errors++; $error("FAIL %s expired observed=%b expected=%b t=%0t", tag, expired, ee, $time);
    end
    checks++;
    assert (remaining === er) else begin
      errors++; $error("FAIL %s remaining observed=%0d expected=%0d t=%0t", tag, remaining, er, $time);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic [1:0] sel, input string tag);
    logic eb, et, ee;
    logic [3:0] er;
    int e;
    start_timer  = s;
    cancel       = c;
    interval_sel = sel;
    @(posedge clk);
    cyc++;
    #1;
    eb = 0; et = 0; ee = 0; er = '0;
    if (s) begin
      active = 1; k = cyc; m_n = param_of(sel);
      eb = 1; er = 4'(m_n);
    end else if (active && c) begin
      active = 0;
    end else if (active) begin
      e = cyc - k;
      if (m_n == 0) begin
        ee = 1; active = 0;
      end else begin
        er = 4'(m_n - e / T);
        et = (e % T == 0);
        ee = (e == m_n * T);
        eb = !ee;
        if (ee) active = 0;
      end
    end
    check_outputs(eb, et, ee, er, tag);
    start_timer = 0;
    cancel      = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, interval_sel, tag);
  endtask

  initial begin
    #12;
    check_outputs(0, 0, 0, 4'd0, "reset_hold");
    @(posedge clk); #1;
    rst = 1;
    idle(3, "post_reset");

    // Arm delay of 3 s
    t_arm = 4'd3;
    step(1, 0, 2'd0, "arm_start");
    idle(14, "arm_count");

    // Zero-length passenger interval
    t_passenger = 4'd0;
    step(1, 0, 2'd2, "zero_start");
    idle(3, "zero_count");

    // Restart of a running alarm-on count with driver interval
    t_alarm = 4'd5;
    step(1, 0, 2'd3, "alarm_start");
    idle(12, "alarm_count");
    t_driver = 4'd2;
    step(1, 0, 2'd1, "restart");
    idle(10, "restart_count");

    // Parameter change during the count must be ignored
    t_driver = 4'd4;
    step(1, 0, 2'd1, "drv_start");
    t_driver = 4'd9;
    interval_sel = 2'd3;
    idle(18, "drv_latched");

    // Cancel at one second left, then start+cancel together
    t_arm = 4'd1;
    step(1, 0, 2'd0, "cancel_start");
    step(0, 1, 2'd0, "cancel");
    idle(20, "after_cancel");
    t_arm = 4'd2;
    step(1, 1, 2'd0, "start_cancel");
    idle(10, "start_cancel_run");

    // Start coinciding with the final tick of a 1 s interval
    t_arm = 4'd1;
    step(1, 0, 2'd0, "final_tick_start");
    idle(3, "final_tick_run");
    t_driver = 4'd1;
    step(1, 0, 2'd1, "start_on_final");
    idle(6, "start_on_final_run");

    // Asynchronous reset mid-count at remaining=2
    t_arm = 4'd3;
    step(1, 0, 2'd0, "rst_start");
    idle(4, "rst_count");
    #2 rst = 0;
    #1;
    check_outputs(0, 0, 0, 4'd0, "async_reset");
    active = 0;
    @(posedge clk); cyc++; #1;
    check_outputs(0, 0, 0, 4'd0, "reset_held");
    rst = 1;
    idle(6, "reset_released");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic s, c;
      t_arm       = 4'($urandom_range(0, 15));
      t_driver    = 4'($urandom_range(0, 15));
      t_passenger = 4'($urandom_range(0, 3));
      t_alarm     = 4'($urandom_range(0, 6));
      s = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 29) == 0);
      step(s, c, 2'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_timer.md
# alarm_timer

Interval timer directly downstream of `time_parameters` in the anti-theft controller. It receives the four programmed delays (`T_ARM_DELAY`, `T_DRIVER_DELAY`, `T_PASSENGER_DELAY`, `T_ALARM_ON`) and counts out the one the main FSM selects. It counts in whole seconds derived from the system clock. It returns a single-cycle `expired` pulse to the FSM.

## Interface

- `TICKS_PER_SEC`, default 100_000_000: clock cycles per one-second tick. The bench overrides it to 4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `interval_sel`  in  2  interval to load on start: 00 arm, 01 driver, 10 passenger, 11 alarm-on. Same encoding as `param_select`.
- `start_timer`  in  1  single-cycle request to load and start the selected interval. Also restarts a running count.
- `cancel`  in  1  abandon the running count without `expired`.
- `T_ARM_DELAY`, `T_DRIVER_DELAY`, `T_PASSENGER_DELAY`, `T_ALARM_ON`  in  4 each  seconds, taken from `time_parameters`.
- `busy`  out  1  high while counting.
- `tick`  out  1  single-cycle pulse on each one-second boundary while counting.
- `remaining`  out  4  seconds left in the current interval.
- `expired`  out  1  single-cycle pulse when the interval completes.

## Operation

- States: `IDLE`, `COUNT`.
- Reset (`rst`=0, asynchronous) forces:
  - state `IDLE`;
  - prescaler 0;
  - `remaining`=0;
  - `busy`, `tick` and `expired` all 0.
- `start_timer` sampled high in either state:
  - `remaining` <= selected parameter;
  - prescaler <= 0;
  - state <= `COUNT`.
- Parameters are latched only at start. Any change to `T_*` or `interval_sel` during a count is ignored until the next start.
- `COUNT` with `remaining`=0 (zero loaded): on the next edge `expired`<=1 and state <= `IDLE`.
- `COUNT` with `remaining`>0:
  - prescaler increments every cycle;
  - at prescaler = `TICKS_PER_SEC`-1 the prescaler wraps to 0, `tick`<=1 and `remaining` decrements;
  - if `remaining` was 1 at that edge, `expired`<=1 in the same edge and state <= `IDLE`.
- `cancel` in `COUNT`: state <= `IDLE`, prescaler <= 0, `remaining` <= 0, no `expired`, no `tick`. `cancel` in `IDLE` has no effect.
- Simultaneous events:
  - `start_timer` and `cancel` together: start wins.
  - `start_timer` coincides with a final tick: start wins, and no `expired` is produced for the abandoned interval.
- `busy` = (state == `COUNT`), registered.
- All outputs are registered.
- Width rules: `remaining` never underflows. The prescaler is $clog2(`TICKS_PER_SEC`) bits and wraps only at terminal count.

## Timing

- Start sampled at edge k with value N>0:
  - `tick` high in the cycles following edges k+T, k+2T … k+N·T, where T=`TICKS_PER_SEC`;
  - `expired` high in the cycle following edge k+N·T, together with the last `tick`.
- N=0: `expired` high in the cycle following edge k+1. No `tick`.
- `busy` rises the cycle after the start edge. It falls in the same cycle `expired` rises.
- `expired` and `tick` are exactly one cycle wide.
- Maximum interval is 15 s.

## Structure

- Shared package `anti_theft_pkg` holds:
  - `interval_sel_t` enum with `SEL_ARM`, `SEL_DRIVER`, `SEL_PASSENGER`, `SEL_ALARM_ON` = 0..3;
  - constant `TIME_W` = 4;
  - `timer_state_t` enum `IDLE`/`COUNT`.
- One sub-module, `sec_prescaler`:
  - parameter `TICKS_PER_SEC`;
  - inputs `clk`, `rst`, `clear`, `enable`;
  - output `sec_pulse`, combinational at terminal count.
- The parameter mux, FSM and `remaining` counter live in `alarm_timer`.

## Test plan

All scenarios use `TICKS_PER_SEC`=4.

1. Reset mid-count: drop `rst` asynchronously while `remaining`=2 -> all outputs are 0 immediately and stay 0 after release.
2. `T_ARM_DELAY`=3, `interval_sel`=00, start at edge k -> `tick` after k+4, k+8, k+12; `remaining` 3,2,1,0; `expired` only after k+12; `busy` falls at the same time.
3. `T_PASSENGER_DELAY`=0, `interval_sel`=10, start -> `expired` one cycle later; no `tick`; `busy` high for exactly one cycle.
4. `T_ALARM_ON`=5 running; at `remaining`=2 issue start with `interval_sel`=01, `T_DRIVER_DELAY`=2 -> count restarts from 2; exactly one `expired`, 8 cycles after the restart.
5. `T_DRIVER_DELAY`=4 started; change it to 9 one cycle later -> `expired` still after 16 cycles.
6. `cancel` at `remaining`=1 -> `busy`=0 and `remaining`=0 next cycle; no `expired` within the following 20 cycles. Then `start_timer` and `cancel` together -> count starts.
